// File: rtl/wt_mem_arbiter.sv
// rtl/wt_mem_arbiter.sv - I$/D$ round-robin arbiter onto one registered memory request slot
// Define WT_ARB_DCACHE_PRIO_EN to replace round-robin with fixed D$ priority.
module wt_mem_arbiter #(
  parameter int ReqWidth       = 128,
  parameter int MaxOutstanding = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                icache_data_req_i,
  output logic                icache_data_ack_o,
  input  logic [ReqWidth-1:0] icache_data_i,
  input  logic                dcache_data_req_i,
  output logic                dcache_data_ack_o,
  input  logic [ReqWidth-1:0] dcache_data_i,
  output logic                mem_req_o,
  output logic [ReqWidth-1:0] mem_data_o,
  output logic                mem_src_o,
  input  logic                mem_gnt_i,
  input  logic                rtrn_vld_i,
  input  logic                rtrn_src_i,
  output logic                icache_rtrn_vld_o,
  output logic                dcache_rtrn_vld_o,
  output logic                busy_o
);

  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] icnt_q, dcnt_q;
  logic slot_free, i_elig, d_elig, capture, win_src;
  logic i_inc, i_dec, d_inc, d_dec;

  assign slot_free = ~mem_req_o | mem_gnt_i;
  assign i_elig    = icache_data_req_i & (icnt_q < CntMax);
  assign d_elig    = dcache_data_req_i & (dcnt_q < CntMax);
  assign capture   = ~rst_i & slot_free & (i_elig | d_elig);

`ifdef WT_ARB_DCACHE_PRIO_EN
  assign win_src = d_elig;
`else
  logic last_src_q;

  // On a tie the requester that did not win last time goes next.
  assign win_src = (i_elig & d_elig) ? ~last_src_q : d_elig;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_src_q <= 1'b1;
    end else if (capture) begin
      last_src_q <= win_src;
    end
  end
`endif

  assign icache_data_ack_o = capture & ~win_src;
  assign dcache_data_ack_o = capture & win_src;

  assign icache_rtrn_vld_o = rtrn_vld_i & ~rtrn_src_i;
  assign dcache_rtrn_vld_o = rtrn_vld_i & rtrn_src_i;

  assign i_inc = icache_data_ack_o;
  assign d_inc = dcache_data_ack_o;
  assign i_dec = icache_rtrn_vld_o;
  assign d_dec = dcache_rtrn_vld_o;

  // Increment cannot overflow because eligibility already excludes a full counter.
  function automatic logic [CntWidth-1:0] cnt_next(
    input logic [CntWidth-1:0] cnt,
    input logic                inc,
    input logic                dec
  );
    logic [CntWidth-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CntWidth'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CntWidth'(1);
    end
    return res;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      icnt_q <= cnt_next(icnt_q, i_inc, i_dec);
      dcnt_q <= cnt_next(dcnt_q, d_inc, d_dec);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o  <= 1'b0;
      mem_data_o <= '0;
      mem_src_o  <= 1'b0;
    end else if (capture) begin
      mem_req_o  <= 1'b1;
      mem_data_o <= win_src ? dcache_data_i : icache_data_i;
      mem_src_o  <= win_src;
    end else if (mem_gnt_i) begin
      mem_req_o  <= 1'b0;
    end
  end

  assign busy_o = mem_req_o | (icnt_q != '0) | (dcnt_q != '0);

  // A return with nothing outstanding indicates a broken memory adapter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(i_dec && !i_inc && (icnt_q == '0)))
        else $warning("wt_mem_arbiter: icache return with no outstanding request");
      assert (!(d_dec && !d_inc && (dcnt_q == '0)))
        else $warning("wt_mem_arbiter: dcache return with no outstanding request");
    end
  end

endmodule

// File: doc/wt_mem_arbiter.md
# wt_mem_arbiter

Shares the single memory request channel of the write-through cache subsystem between the instruction cache and the data cache. The block sits between the two cache miss/write request ports and the memory adapter (AXI or L15). It performs round-robin arbitration into a one-entry output register. It tracks outstanding transactions per requester, throttles a requester at its limit, and steers return-valid strobes back to the owning cache.

## Interface
Parameters:
- ReqWidth, 128, width of the opaque request payload (packed cache request struct)
- MaxOutstanding, 8, maximum in-flight transactions per requester; must be ≥1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- icache_data_req_i  in  1  I$ request valid, held until acked
- icache_data_ack_o  out  1  one-cycle acceptance of I$ request
- icache_data_i  in  ReqWidth  I$ request payload
- dcache_data_req_i  in  1  D$ request valid, held until acked
- dcache_data_ack_o  out  1  one-cycle acceptance of D$ request
- dcache_data_i  in  ReqWidth  D$ request payload
- mem_req_o  out  1  output register valid
- mem_data_o  out  ReqWidth  registered payload
- mem_src_o  out  1  owner of mem_data_o (0 = I$, 1 = D$)
- mem_gnt_i  in  1  memory side accepts mem_data_o this cycle
- rtrn_vld_i  in  1  memory return valid
- rtrn_src_i  in  1  owner of the return (0 = I$, 1 = D$)
- icache_rtrn_vld_o  out  1  rtrn_vld_i & ~rtrn_src_i (combinational)
- dcache_rtrn_vld_o  out  1  rtrn_vld_i & rtrn_src_i (combinational)
- busy_o  out  1  output register valid or any outstanding count non-zero

## Operation
- Slot free = ~mem_req_o | mem_gnt_i. Capture happens when the slot is free and at least one eligible request is present.
- A requester is eligible when its req is high and its outstanding count < MaxOutstanding.
- Round-robin: a 1-bit last_src register. When both requesters are eligible, the one ≠ last_src wins. A single eligible requester always wins.
- On capture: the winner's ack_o = 1 in the same cycle (combinational from req and registered state). mem_data_o, mem_src_o and mem_req_o load at the next edge. last_src ← winner. The winner's outstanding counter increments.
- Counters are clog2(MaxOutstanding+1) bits. They decrement on rtrn_vld_i for rtrn_src_i.
- If a counter increments and decrements in the same cycle, its value is unchanged.
- A decrement at 0 saturates at 0 (no wrap). Simulation assertion fires in that case.
- At most one ack is asserted per cycle. The ack never asserts while the slot is busy and mem_gnt_i = 0.
- mem_data_o and mem_src_o are stable while mem_req_o = 1 and mem_gnt_i = 0.

## Timing
- Reset values: mem_req_o=0, mem_data_o=0, mem_src_o=0, last_src=1 (I$ wins the first tie), both counters 0, busy_o=0. Ack and rtrn outputs are 0 when the inputs are idle.
- Latency from req to mem_req_o: one cycle when the slot is free.
- Back-to-back throughput: mem_gnt_i held at 1 sustains one capture per cycle. With both requesters eligible, captures alternate I$, D$, I$, ...
- Return steering is zero-latency. Counter effect is visible in the next cycle.
- Reset mid-operation: the slot is dropped and counters clear. Acks are suppressed during the reset cycle.

## Configuration
- WT_ARB_DCACHE_PRIO_EN:
  - Defined: fixed priority. D$ always wins a tie and last_src is ignored; I$ starves while D$ stays eligible.
  - Undefined: round-robin as above.
- Counter and throttle behaviour is identical in both builds.

## Test plan
- Reset, then I$ req with payload 0xA5 and mem_gnt_i=1 → icache_data_ack_o=1 in cycle 0. mem_req_o=1, mem_data_o=0xA5, mem_src_o=0 in cycle 1. busy_o=1.
- Both requesters held for 6 cycles with mem_gnt_i=1 → source order 0,1,0,1,0,1. Under WT_ARB_DCACHE_PRIO_EN the order is 1,1,1,1,1,1.
- mem_gnt_i=0 for 4 cycles with the slot full → no acks. mem_data_o and mem_src_o are unchanged. Capture resumes in the cycle mem_gnt_i=1.
- MaxOutstanding=2: D$ issues 2 requests with no returns → third D$ request is not acked while I$ requests still pass. A single rtrn_vld_i with rtrn_src_i=1 → the D$ ack follows in the next cycle.
- Capture for D$ coincides with a D$ return at count 1 → count stays 1. A return for I$ at count 0 → count stays 0 and the assertion fires.
- rst_i asserted while mem_req_o=1 with counts 3/2 → next cycle all outputs are 0, counters are 0 and busy_o=0.
